// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and constants for the datapath load/store memory port.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int DEFAULT_DEPTH_WORDS = 64;
  localparam int DEFAULT_WAIT_STATES = 2;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_array
// Single-port word memory: synchronous write, synchronous registered read.
// Contents and read register are deliberately not reset.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_array #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Enabled cycle either writes the word or captures it into the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_responder
// Load/store responder: valid/ready request, programmable wait states,
// response held until accepted, error for misaligned/out-of-range addresses.
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int          WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     cnt;

  logic           lat_write;
  logic           lat_err;
  logic [AW-1:0]  lat_idx;
  logic [31:0]    lat_wdata;

  logic           resp_load;
  logic [31:0]    mem_rdata;

  logic           accept;
  logic           access;
  logic           acc_write;
  logic           acc_err;
  logic [AW-1:0]  acc_idx;
  logic [31:0]    acc_wdata;

  logic [31:0]    req_off;
  logic           req_err;
  logic [AW-1:0]  req_idx;

  // Unsigned offset makes addresses below BASE_ADDR wrap and fail the span test.
  assign req_off = req_addr - BASE_ADDR;
  assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_off} >= SPAN);
  assign req_idx = req_off[AW+1:2];

  assign req_ready = (state == ST_IDLE) && reset;
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request fields are used instead of the latched copy.
  assign acc_write = (state == ST_IDLE) ? req_write : lat_write;
  assign acc_err   = (state == ST_IDLE) ? req_err   : lat_err;
  assign acc_idx   = (state == ST_IDLE) ? req_idx   : lat_idx;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;

  // Load data is only exposed for successful loads; otherwise forced to zero.
  assign resp_rdata = resp_load ? mem_rdata : 32'd0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and access strobe.
  always_comb begin
    state_nx = state;
    access   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            access   = 1'b1;
            state_nx = ST_RESP;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          access   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_valid && resp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture and wait-state counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_write <= req_write;
      lat_err   <= req_err;
      lat_idx   <= req_idx;
      lat_wdata <= req_wdata;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers: loaded on the access edge, cleared on the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_err   <= RESP_OK;
      resp_load  <= 1'b0;
    end else if (access) begin
      resp_valid <= 1'b1;
      resp_err   <= acc_err ? RESP_ERR : RESP_OK;
      resp_load  <= !acc_write && !acc_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
      resp_err   <= RESP_OK;
      resp_load  <= 1'b0;
    end
  end

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (32),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .en    (access && !acc_err),
    .we    (acc_write),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench: a 2-wait-state instance and a 0-wait-state instance.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs [11];
  exp_t sbq [$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request on the WS=2 instance; hold>0 keeps resp_ready low that many cycles.
  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int hold);
    exp_t e;
    int   n;
    int   acc_e;
    int   hs_e;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc_e   = cyc;
    e.rdata = er;
    e.err   = ee;
    sbq.push_back(e);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin tick(); n++; end
    if (!resp_valid) begin
      check("resp_timeout", 32'd0, 32'd1);
      e = sbq.pop_front();
      resp_ready = 1'b1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_valid",     32'(resp_valid), 32'd1);
      check("hold_rdata",     resp_rdata,      sbq[0].rdata);
      check("hold_err",       32'(resp_err),   32'(sbq[0].err));
      check("hold_req_ready", 32'(req_ready),  32'd0);
      tick();
    end
    resp_ready = 1'b1;
    e = sbq.pop_front();
    check("rdata", resp_rdata, e.rdata);
    check("err", 32'(resp_err), 32'(e.err));
    hs_e = cyc;
    tick();
    if (hold == 0) check("latency", 32'(hs_e - acc_e), 32'(WS + 1));
    check("busy_after_handshake", 32'(busy), 32'd0);
  endtask

  // One request on the zero-wait-state instance.
  task automatic b_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    int   acc_e;
    int   hs_e;
    b_req_write  = w;
    b_req_addr   = a;
    b_req_wdata  = wd;
    b_req_valid  = 1'b1;
    b_resp_ready = 1'b1;
    n = 0;
    while (!b_req_ready && n < 20) begin tick(); n++; end
    if (!b_req_ready) begin
      check("b_req_ready_timeout", 32'd0, 32'd1);
      b_req_valid = 1'b0;
      return;
    end
    acc_e   = cyc;
    e.rdata = er;
    e.err   = ee;
    sbq.push_back(e);
    tick();
    b_req_valid = 1'b0;
    n = 0;
    while (!b_resp_valid && n < 10) begin tick(); n++; end
    if (!b_resp_valid) begin
      check("b_resp_timeout", 32'd0, 32'd1);
      e = sbq.pop_front();
      return;
    end
    e = sbq.pop_front();
    check("b_rdata", b_resp_rdata, e.rdata);
    check("b_err", 32'(b_resp_err), 32'(e.err));
    hs_e = cyc;
    tick();
    check("b_latency", 32'(hs_e - acc_e), 32'd1);
  endtask

  logic        bb_w [6];
  logic [31:0] bb_a [6];
  logic [31:0] bb_d [6];
  logic [31:0] bb_r [6];

  initial begin
    exp_t e;
    int   idx;
    int   last;
    int   done;
    int   guard;
    logic acc;
    logic rsp;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0012, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_00FC, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'h1122_3344, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};

    bb_w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bb_a = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h0, 32'h0};
    bb_d = '{32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0, 32'h3333_3333, 32'h0};
    bb_r = '{32'h0, 32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0, 32'h3333_3333};

    // Reset state.
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_b_req_ready", 32'(b_req_ready), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Table-driven single transactions.
    for (int i = 0; i < 11; i++) begin
      transact(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 0);
    end

    // Response held for 10 cycles by a stalled requester.
    transact(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 10);

    // Continuous req_valid with alternating stores/loads.
    idx = 0; last = -1; done = 0; guard = 0;
    resp_ready = 1'b1;
    req_write = bb_w[0]; req_addr = bb_a[0]; req_wdata = bb_d[0]; req_valid = 1'b1;
    while (done < 6 && guard < 80) begin
      acc = req_valid && req_ready;
      rsp = resp_valid && resp_ready;
      if (rsp) begin
        if (sbq.size() == 0) begin
          check("bb_unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("bb_rdata", resp_rdata, e.rdata);
          check("bb_err", 32'(resp_err), 32'(e.err));
        end
        done++;
      end
      if (acc) begin
        e.rdata = bb_r[idx];
        e.err   = 1'b0;
        sbq.push_back(e);
        if (last >= 0) check("bb_spacing", 32'(cyc - last), 32'd4);
        last = cyc;
      end
      tick();
      guard++;
      if (acc) begin
        idx++;
        if (idx < 6) begin
          req_write = bb_w[idx]; req_addr = bb_a[idx]; req_wdata = bb_d[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    if (done < 6) check("bb_timeout", 32'(done), 32'd6);
    sbq.delete();

    // Reset during WAIT of a store: store dropped, memory unchanged.
    req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("wait_busy", 32'(busy), 32'd1);
    tick();
    #2 reset = 1'b0;
    #1;
    check("wrst_resp_valid", 32'(resp_valid), 32'd0);
    check("wrst_busy",       32'(busy),       32'd0);
    check("wrst_req_ready",  32'(req_ready),  32'd0);
    check("wrst_resp_rdata", resp_rdata,      32'd0);
    check("wrst_resp_err",   32'(resp_err),   32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    transact(1'b0, 32'h8, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);

    // Reset during RESP: response discarded asynchronously.
    resp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin tick(); guard++; end
    check("rresp_valid_before", 32'(resp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rresp_valid_drop", 32'(resp_valid), 32'd0);
    check("rresp_rdata_drop", resp_rdata,      32'd0);
    tick();
    reset = 1'b1;
    tick();
    transact(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Zero-wait-state instance.
    b_txn(1'b1, 32'h3C, 32'hCAFE_F00D, 32'h0, 1'b0);
    b_txn(1'b0, 32'h3C, 32'h0, 32'hCAFE_F00D, 1'b0);
    b_txn(1'b0, 32'h3E, 32'h0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
